// File: rtl/ogege_bus_pkg.sv
// Shared definitions for the 32-bit memory/peripheral bus and its DMA initiator.
package ogege_bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;

   localparam logic [7:0] TEXT_BASE  = 8'h10;
   localparam logic [7:0] PSRAM_BASE = 8'h40;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_REQ = 3'd1,
      ST_RD_GAP = 3'd2,
      ST_WR_REQ = 3'd3,
      ST_WR_GAP = 3'd4,
      ST_FINISH = 3'd5
   } dma_state_t;

   // Byte elements travel in the low lane of the data bus.
   function automatic logic [BUS_DATA_W-1:0] byte_lane(input logic [7:0] b);
      return {24'd0, b};
   endfunction

endpackage

// File: rtl/bus_access_req.sv
// One bus access: owns the strobe, holds addr/we/data while it is high, and
// bounds the wait for the responder's ready.
module bus_access_req
   import ogege_bus_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  launch,
   input  logic                  launch_we,
   input  logic [BUS_ADDR_W-1:0] launch_addr,
   input  logic [BUS_DATA_W-1:0] launch_data,
   input  logic                  ready,
   output logic                  strobe,
   output logic                  we,
   output logic [BUS_ADDR_W-1:0] addr,
   output logic [BUS_DATA_W-1:0] data,
   output logic                  ack,
   output logic                  timeout
);

   localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT);

   logic [15:0] wait_r;

   assign ack     = strobe & ready;
   assign timeout = strobe & ~ready & (wait_r == WAIT_MAX);

   // Strobe, held access fields and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe <= 1'b0;
         we     <= 1'b0;
         addr   <= {BUS_ADDR_W{1'b0}};
         data   <= {BUS_DATA_W{1'b0}};
         wait_r <= 16'd0;
      end else if (launch) begin
         strobe <= 1'b1;
         we     <= launch_we;
         addr   <= launch_addr;
         data   <= launch_data;
         wait_r <= 16'd0;
      end else if (ack || timeout) begin
         strobe <= 1'b0;
      end else if (strobe) begin
         wait_r <= wait_r + 16'd1;
      end
   end

endmodule

// File: rtl/bus_dma_initiator.sv
// Bus-initiator DMA engine: copies or fills a run of byte elements between bus
// addresses, sequencing src/dst/count around a single-access requester.
module bus_dma_initiator
   import ogege_bus_pkg::*;
#(
   parameter int LENW    = 16,
   parameter int STEP    = 1,
   parameter int TIMEOUT = 255
) (
   input  logic                  i_cpu_clk,
   input  logic                  i_rstn,
   input  logic                  i_start,
   input  logic                  i_mode,
   input  logic [BUS_ADDR_W-1:0] i_src,
   input  logic [BUS_ADDR_W-1:0] i_dst,
   input  logic [LENW-1:0]       i_len,
   input  logic [7:0]            i_fill,
   input  logic                  i_abort,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [LENW-1:0]       o_remaining,
   output logic                  o_bus_clk,
   output logic                  o_bus_we,
   output logic [BUS_ADDR_W-1:0] o_bus_addr,
   output logic [BUS_DATA_W-1:0] o_bus_data,
   input  logic [BUS_DATA_W-1:0] i_bus_data,
   input  logic                  i_bus_data_ready
);

   localparam logic [BUS_ADDR_W-1:0] ADDR_STEP = BUS_ADDR_W'(STEP);
   localparam logic [LENW-1:0]       LEN_ZERO  = {LENW{1'b0}};
   localparam logic [LENW-1:0]       LEN_ONE   = LENW'(1);

   dma_state_t            state_r, state_s;
   logic [BUS_ADDR_W-1:0] src_r, dst_r;
   logic [LENW-1:0]       rem_r;
   logic                  mode_r, busy_r, done_r, error_r;
   logic [7:0]            fill_r, byte_r;
   logic                  accept_s, launch_s, launch_we_s, ack_s, timeout_s;
   logic [BUS_ADDR_W-1:0] launch_addr_s;
   logic [BUS_DATA_W-1:0] launch_data_s;
   logic [23:0]           unused_bus_bits;

   assign unused_bus_bits = i_bus_data[31:8];

   // busy_r stays high through the done pulse, so a start coinciding with done is refused.
   assign accept_s = (state_r == ST_IDLE) & i_start & ~busy_r;

   bus_access_req #(.TIMEOUT(TIMEOUT)) u_access (
      .clk         (i_cpu_clk),
      .rst_n       (i_rstn),
      .launch      (launch_s),
      .launch_we   (launch_we_s),
      .launch_addr (launch_addr_s),
      .launch_data (launch_data_s),
      .ready       (i_bus_data_ready),
      .strobe      (o_bus_clk),
      .we          (o_bus_we),
      .addr        (o_bus_addr),
      .data        (o_bus_data),
      .ack         (ack_s),
      .timeout     (timeout_s)
   );

   // FSM state register.
   always_ff @(posedge i_cpu_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and access launch; abort is only honoured between accesses.
   always_comb begin
      state_s       = state_r;
      launch_s      = 1'b0;
      launch_we_s   = 1'b1;
      launch_addr_s = dst_r;
      launch_data_s = byte_lane(fill_r);
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (i_len == LEN_ZERO || i_abort) begin
                  state_s = ST_FINISH;
               end else if (i_mode) begin
                  state_s       = ST_WR_REQ;
                  launch_s      = 1'b1;
                  launch_addr_s = i_dst;
                  launch_data_s = byte_lane(i_fill);
               end else begin
                  state_s       = ST_RD_REQ;
                  launch_s      = 1'b1;
                  launch_we_s   = 1'b0;
                  launch_addr_s = i_src;
                  launch_data_s = {BUS_DATA_W{1'b0}};
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD_REQ: begin
            if (ack_s) begin
               state_s = ST_RD_GAP;
            end else if (timeout_s) begin
               state_s = ST_FINISH;
            end else begin
               state_s = ST_RD_REQ;
            end
         end
         ST_RD_GAP: begin
            if (i_abort) begin
               state_s = ST_FINISH;
            end else begin
               state_s       = ST_WR_REQ;
               launch_s      = 1'b1;
               launch_data_s = byte_lane(byte_r);
            end
         end
         ST_WR_REQ: begin
            if (ack_s) begin
               state_s = ST_WR_GAP;
            end else if (timeout_s) begin
               state_s = ST_FINISH;
            end else begin
               state_s = ST_WR_REQ;
            end
         end
         ST_WR_GAP: begin
            if (rem_r == LEN_ONE || i_abort) begin
               state_s = ST_FINISH;
            end else if (mode_r) begin
               state_s       = ST_WR_REQ;
               launch_s      = 1'b1;
               launch_addr_s = dst_r + ADDR_STEP;
            end else begin
               state_s       = ST_RD_REQ;
               launch_s      = 1'b1;
               launch_we_s   = 1'b0;
               launch_addr_s = src_r;
               launch_data_s = {BUS_DATA_W{1'b0}};
            end
         end
         ST_FINISH: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Command latch, address/count progress and status flags.
   always_ff @(posedge i_cpu_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         src_r   <= {BUS_ADDR_W{1'b0}};
         dst_r   <= {BUS_ADDR_W{1'b0}};
         rem_r   <= LEN_ZERO;
         mode_r  <= 1'b0;
         fill_r  <= 8'd0;
         byte_r  <= 8'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         done_r <= (state_r == ST_FINISH);
         if (accept_s) begin
            src_r   <= i_src;
            dst_r   <= i_dst;
            rem_r   <= i_len;
            mode_r  <= i_mode;
            fill_r  <= i_fill;
            busy_r  <= 1'b1;
            error_r <= 1'b0;
         end else begin
            if (done_r) begin
               busy_r <= 1'b0;
            end
            if (timeout_s) begin
               error_r <= 1'b1;
            end
            if (state_r == ST_RD_REQ && ack_s) begin
               byte_r <= i_bus_data[7:0];
            end
            if (state_r == ST_RD_GAP) begin
               src_r <= src_r + ADDR_STEP;
            end
            if (state_r == ST_WR_GAP) begin
               dst_r <= dst_r + ADDR_STEP;
               rem_r <= rem_r - LEN_ONE;
            end
         end
      end
   end

   assign o_busy      = busy_r;
   assign o_done      = done_r;
   assign o_error     = error_r;
   assign o_remaining = rem_r;

endmodule
